// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        IMEM = 3'd1,
        DMEM = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

    // True while the loader is still consuming stream bytes.
    function automatic logic is_loading(input state_t st);
        logic res;
        case (st)
            HDR, IMEM, DMEM: res = 1'b1;
            default:         res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Packs accepted stream bytes into little-endian 32-bit words; the first byte lands in bits [7:0].
module byte_word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        arst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic        word_done,
    output logic [31:0] word
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt_r;
    logic [31:0] shift_r;

    // The completed word is presented in the same cycle its last byte is accepted.
    assign word_done = accept & (cnt_r == LAST_BYTE);
    assign word      = {data, shift_r[31:8]};

    // Byte counter and shift register; bytes enter at the top and move toward the LSB.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_r   <= 2'd0;
            shift_r <= 32'd0;
        end else if (clear) begin
            cnt_r   <= 2'd0;
            shift_r <= 32'd0;
        end else if (accept) begin
            cnt_r   <= cnt_r + 2'd1;
            shift_r <= {data, shift_r[31:8]};
        end else begin
            cnt_r   <= cnt_r;
            shift_r <= shift_r;
        end
    end

endmodule

// File: rtl/cpu_program_loader.sv
// Streams a header plus instruction/data words into the CPU's SRAM ports, then enables the CPU.
module cpu_program_loader
    import loader_pkg::*;
#(
    parameter int IMEM_WORDS = 128,
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic [31:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [31:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [31:0] wdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        error
);

    localparam logic [16:0] IMEM_LIMIT = 17'(IMEM_WORDS);
    localparam logic [16:0] DMEM_LIMIT = 17'(DMEM_WORDS);
    localparam int          HALF_HDR   = 8 * HDR_BYTES / 2;

    state_t      state_r;
    state_t      state_next_s;
    logic        accept_s;
    logic        clear_s;
    logic        word_done_s;
    logic [31:0] word_s;
    logic [15:0] hdr_n_i_s;
    logic [15:0] hdr_n_d_s;
    logic [15:0] n_i_r;
    logic [15:0] n_d_r;
    logic [15:0] idx_r;
    logic        imem_wr_s;
    logic        dmem_wr_s;

    logic        s_ready_r;
    logic        busy_r;
    logic        error_r;
    logic        cpu_enable_r;
    logic        wen_ext_r;
    logic [31:0] addr_ext_r;
    logic [31:0] wdata_ext_r;
    logic        wen_ext_2_r;
    logic [31:0] addr_ext_2_r;
    logic [31:0] wdata_ext_2_r;

    assign accept_s = s_valid & s_ready_r;

    // The header is gathered by the same assembler as payload words.
    assign hdr_n_i_s = word_s[HALF_HDR-1:0];
    assign hdr_n_d_s = word_s[2*HALF_HDR-1:HALF_HDR];

    assign imem_wr_s = word_done_s & (state_r == IMEM);
    assign dmem_wr_s = word_done_s & (state_r == DMEM);

    // Any state change discards whatever partial word the assembler holds.
    assign clear_s = (state_next_s != state_r);

    byte_word_assembler u_asm (
        .clk       (clk),
        .arst      (arst),
        .clear     (clear_s),
        .accept    (accept_s),
        .data      (s_data),
        .word_done (word_done_s),
        .word      (word_s)
    );

    // Next-state decode; counts are range-checked here so the word index never wraps.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            HDR: begin
                if (word_done_s) begin
                    if (({1'b0, hdr_n_i_s} > IMEM_LIMIT) || ({1'b0, hdr_n_d_s} > DMEM_LIMIT)) begin
                        state_next_s = ERR;
                    end else if (hdr_n_i_s != 16'd0) begin
                        state_next_s = IMEM;
                    end else if (hdr_n_d_s != 16'd0) begin
                        state_next_s = DMEM;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            IMEM: begin
                if (word_done_s && (idx_r == n_i_r - 16'd1)) begin
                    state_next_s = (n_d_r != 16'd0) ? DMEM : RUN;
                end else begin
                    state_next_s = state_r;
                end
            end
            DMEM: begin
                if (word_done_s && (idx_r == n_d_r - 16'd1)) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = state_r;
                end
            end
            RUN:     state_next_s = RUN;
            ERR:     state_next_s = ERR;
            default: state_next_s = ERR;
        endcase
    end

    // FSM, header counts, word index and status outputs.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r      <= HDR;
            n_i_r        <= 16'd0;
            n_d_r        <= 16'd0;
            idx_r        <= 16'd0;
            s_ready_r    <= 1'b0;
            busy_r       <= 1'b0;
            error_r      <= 1'b0;
            cpu_enable_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            s_ready_r    <= is_loading(state_next_s);
            busy_r       <= is_loading(state_next_s);
            error_r      <= (state_next_s == ERR);
            cpu_enable_r <= (state_r == RUN);
            if (state_r == HDR && word_done_s) begin
                n_i_r <= hdr_n_i_s;
                n_d_r <= hdr_n_d_s;
            end else begin
                n_i_r <= n_i_r;
                n_d_r <= n_d_r;
            end
            if (clear_s) begin
                idx_r <= 16'd0;
            end else if (imem_wr_s || dmem_wr_s) begin
                idx_r <= idx_r + 16'd1;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Registered write ports; address and data hold their last value between strobes.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wen_ext_r     <= 1'b0;
            addr_ext_r    <= 32'd0;
            wdata_ext_r   <= 32'd0;
            wen_ext_2_r   <= 1'b0;
            addr_ext_2_r  <= 32'd0;
            wdata_ext_2_r <= 32'd0;
        end else begin
            wen_ext_r   <= imem_wr_s;
            wen_ext_2_r <= dmem_wr_s;
            if (imem_wr_s) begin
                addr_ext_r  <= {14'd0, idx_r, 2'b00};
                wdata_ext_r <= word_s;
            end else begin
                addr_ext_r  <= addr_ext_r;
                wdata_ext_r <= wdata_ext_r;
            end
            if (dmem_wr_s) begin
                addr_ext_2_r  <= {14'd0, idx_r, 2'b00};
                wdata_ext_2_r <= word_s;
            end else begin
                addr_ext_2_r  <= addr_ext_2_r;
                wdata_ext_2_r <= wdata_ext_2_r;
            end
        end
    end

    assign s_ready     = s_ready_r;
    assign busy        = busy_r;
    assign error       = error_r;
    assign cpu_enable  = cpu_enable_r;
    assign wen_ext     = wen_ext_r;
    assign addr_ext    = addr_ext_r;
    assign wdata_ext   = wdata_ext_r;
    assign ren_ext     = 1'b0;
    assign wen_ext_2   = wen_ext_2_r;
    assign addr_ext_2  = addr_ext_2_r;
    assign wdata_ext_2 = wdata_ext_2_r;
    assign ren_ext_2   = 1'b0;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed bench for cpu_program_loader: normal load, stalled stream, empty/oversized headers, mid-load reset.
module tb_cpu_program_loader;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_ready;
    logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic        cpu_enable, busy, error;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [31:0] im_a[$], im_d[$], dm_a[$], dm_d[$];
    int          im_c[$], dm_c[$];

    cpu_program_loader #(.IMEM_WORDS(128), .DMEM_WORDS(256)) dut (
        .clk(clk), .arst(arst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .cpu_enable(cpu_enable), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe seen mid-cycle.
    always @(negedge clk) begin
        if (wen_ext) begin
            im_a.push_back(addr_ext); im_d.push_back(wdata_ext); im_c.push_back(cyc);
        end
        if (wen_ext_2) begin
            dm_a.push_back(addr_ext_2); dm_d.push_back(wdata_ext_2); dm_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        im_a.delete(); im_d.delete(); im_c.delete();
        dm_a.delete(); dm_d.delete(); dm_c.delete();
    endtask

    // Assert reset asynchronously, check every output is cleared, then release.
    task automatic do_reset();
        s_valid = 1'b0;
        arst = 1'b1;
        #2;
        chk("rst_ctrl", {26'd0, s_ready, wen_ext, wen_ext_2, cpu_enable, busy, error}, 32'd0);
        chk("rst_ren", {30'd0, ren_ext, ren_ext_2}, 32'd0);
        chk("rst_addr", addr_ext | addr_ext_2, 32'd0);
        chk("rst_wdata", wdata_ext | wdata_ext_2, 32'd0);
        clear_log();
        repeat (2) @(posedge clk);
        #2 arst = 1'b0;
        @(posedge clk); #1;
        chk("rel_ready", {31'd0, s_ready}, 32'd1);
        chk("rel_busy", {31'd0, busy}, 32'd1);
    endtask

    // Present one byte and return #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b, input bit tog);
        bit got;
        if (tog) begin
            int n;
            n = $urandom_range(0, 2);
            repeat (n) begin
                s_valid = 1'b0;
                s_data = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b1;
        s_data = b;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = s_ready;
            @(posedge clk); #1;
        end
        if (!got) chk("byte_accept_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit tog);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], tog);
    endtask

    task automatic check_basic_log(input string tag);
        chk({tag, "_im_n"}, 32'(im_a.size()), 32'd2);
        chk({tag, "_dm_n"}, 32'(dm_a.size()), 32'd1);
        if (im_a.size() == 2 && dm_a.size() == 1) begin
            chk({tag, "_im0_a"}, im_a[0], 32'h0);
            chk({tag, "_im0_d"}, im_d[0], 32'h20080005);
            chk({tag, "_im1_a"}, im_a[1], 32'h4);
            chk({tag, "_im1_d"}, im_d[1], 32'h01094020);
            chk({tag, "_dm0_a"}, dm_a[0], 32'h0);
            chk({tag, "_dm0_d"}, dm_d[0], 32'hDEADBEEF);
        end
    endtask

    initial begin
        int bad;

        // Basic load, s_valid held high.
        do_reset();
        send_word(32'h0001_0002, 1'b0);
        send_word(32'h20080005, 1'b0);
        chk("t1_w0_wen", {31'd0, wen_ext}, 32'd1);
        chk("t1_w0_addr", addr_ext, 32'h0);
        chk("t1_w0_data", wdata_ext, 32'h20080005);
        send_word(32'h01094020, 1'b0);
        chk("t1_w1_addr", addr_ext, 32'h4);
        send_word(32'hDEADBEEF, 1'b0);
        s_valid = 1'b0;
        chk("t1_dm_wen", {31'd0, wen_ext_2}, 32'd1);
        chk("t1_dm_addr", addr_ext_2, 32'h0);
        chk("t1_dm_data", wdata_ext_2, 32'hDEADBEEF);
        chk("t1_ready_low", {31'd0, s_ready}, 32'd0);
        chk("t1_en_not_yet", {31'd0, cpu_enable}, 32'd0);
        @(posedge clk); #1;
        chk("t1_en_rise", {31'd0, cpu_enable}, 32'd1);
        chk("t1_wen2_single", {31'd0, wen_ext_2}, 32'd0);
        chk("t1_busy_low", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk); #1;
        check_basic_log("t1");
        if (im_c.size() == 2 && dm_c.size() == 1) begin
            chk("t1_spacing_im", 32'(im_c[1] - im_c[0]), 32'd4);
            chk("t1_spacing_dm", 32'(dm_c[0] - im_c[1]), 32'd4);
        end

        // Same stream with random stalls and junk data while s_valid is low.
        do_reset();
        send_word(32'h0001_0002, 1'b1);
        send_word(32'h20080005, 1'b1);
        send_word(32'h01094020, 1'b1);
        send_word(32'hDEADBEEF, 1'b1);
        s_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_basic_log("t2");
        chk("t2_enable", {31'd0, cpu_enable}, 32'd1);

        // Empty header goes straight to RUN.
        do_reset();
        send_word(32'h0000_0000, 1'b0);
        s_valid = 1'b0;
        chk("t3_ready_low", {31'd0, s_ready}, 32'd0);
        chk("t3_en_not_yet", {31'd0, cpu_enable}, 32'd0);
        @(posedge clk); #1;
        chk("t3_en_rise", {31'd0, cpu_enable}, 32'd1);
        repeat (3) @(posedge clk); #1;
        chk("t3_no_writes", 32'(im_a.size() + dm_a.size()), 32'd0);

        // n_i one past the limit is rejected.
        do_reset();
        send_word(32'h0000_0081, 1'b0);
        chk("t4_error", {31'd0, error}, 32'd1);
        chk("t4_ready_low", {31'd0, s_ready}, 32'd0);
        repeat (5) @(posedge clk); #1;
        s_valid = 1'b0;
        chk("t4_error_hold", {31'd0, error}, 32'd1);
        chk("t4_no_enable", {31'd0, cpu_enable}, 32'd0);
        chk("t4_busy_low", {31'd0, busy}, 32'd0);
        chk("t4_no_writes", 32'(im_a.size() + dm_a.size()), 32'd0);

        // n_d one past the limit is rejected.
        do_reset();
        send_word(32'h0101_0000, 1'b0);
        s_valid = 1'b0;
        chk("t4b_error", {31'd0, error}, 32'd1);

        // n_i exactly at the limit.
        do_reset();
        send_word(32'h0000_0080, 1'b0);
        chk("t4c_no_error", {31'd0, error}, 32'd0);
        for (int i = 0; i < 128; i++) send_word(32'h1000_0000 + 32'(i), 1'b0);
        s_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("t4c_im_n", 32'(im_a.size()), 32'd128);
        chk("t4c_enable", {31'd0, cpu_enable}, 32'd1);
        bad = 0;
        for (int i = 0; i < im_a.size(); i++)
            if (im_a[i] !== 32'(4 * i) || im_d[i] !== 32'h1000_0000 + 32'(i)) bad++;
        chk("t4c_all_words", 32'(bad), 32'd0);
        if (im_a.size() == 128) chk("t4c_last_addr", im_a[127], 32'h1FC);

        // n_d exactly at the limit.
        do_reset();
        send_word(32'h0100_0000, 1'b0);
        for (int i = 0; i < 256; i++) send_word(32'hA500_0000 + 32'(i), 1'b0);
        s_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("t4d_dm_n", 32'(dm_a.size()), 32'd256);
        if (dm_a.size() == 256) begin
            chk("t4d_last_addr", dm_a[255], 32'h3FC);
            chk("t4d_last_data", dm_d[255], 32'hA500_00FF);
        end
        chk("t4d_enable", {31'd0, cpu_enable}, 32'd1);

        // Reset after two bytes of word 1; partial word must vanish.
        do_reset();
        send_word(32'h0001_0002, 1'b0);
        send_word(32'h20080005, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h40, 1'b0);
        s_valid = 1'b0;
        chk("t5_pre_writes", 32'(im_a.size()), 32'd1);
        do_reset();
        send_word(32'h0000_0001, 1'b0);
        send_word(32'hCAFEF00D, 1'b0);
        s_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("t5_im_n", 32'(im_a.size()), 32'd1);
        if (im_a.size() == 1) begin
            chk("t5_addr", im_a[0], 32'h0);
            chk("t5_data", im_d[0], 32'hCAFEF00D);
        end
        chk("t5_dm_n", 32'(dm_a.size()), 32'd0);
        chk("t5_enable", {31'd0, cpu_enable}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
